// File: rtl/bos_pkg.sv
// rtl/bos_pkg.sv - shared state encoding, slot map and step-write table for the BOS power sequencer
package bos_pkg;

    typedef enum logic [3:0] {
        ST_OFF      = 4'd0,
        ST_UP_VCORE = 4'd1,
        ST_UP_VDIG  = 4'd2,
        ST_UP_FUNC  = 4'd3,
        ST_UP_RST   = 4'd4,
        ST_UP_REL   = 4'd5,
        ST_ON       = 4'd6,
        ST_DN_RST   = 4'd7,
        ST_DN_FUNC  = 4'd8,
        ST_DN_VDIG  = 4'd9,
        ST_DN_VCORE = 4'd10
    } state_e;

    localparam int unsigned SLOT_FUNC  = 6;
    localparam int unsigned SLOT_VCORE = 7;
    localparam int unsigned SLOT_VDIG  = 8;
    localparam int unsigned SLOT_RSTBY = 9;

    typedef struct packed {
        logic [9:0] strb;
        logic [7:0] data;
    } wr_t;

    function automatic logic [9:0] slot_strb(input int unsigned slot);
        return 10'd1 << slot;
    endfunction

    function automatic logic is_up(input state_e st);
        return st inside {ST_UP_VCORE, ST_UP_VDIG, ST_UP_FUNC, ST_UP_RST, ST_UP_REL};
    endfunction

    // The single register write each step state makes on its first cycle
    function automatic wr_t step_write(input state_e st);
        wr_t w;
        w = '0;
        case (st)
            ST_UP_VCORE: begin w.strb = slot_strb(SLOT_VCORE); w.data = 8'h00; end
            ST_UP_VDIG:  begin w.strb = slot_strb(SLOT_VDIG);  w.data = 8'h00; end
            ST_UP_FUNC:  begin w.strb = slot_strb(SLOT_FUNC);  w.data = 8'h01; end
            ST_UP_RST:   begin w.strb = slot_strb(SLOT_RSTBY); w.data = 8'h01; end
            ST_UP_REL:   begin w.strb = slot_strb(SLOT_RSTBY); w.data = 8'h00; end
            ST_DN_RST:   begin w.strb = slot_strb(SLOT_RSTBY); w.data = 8'h01; end
            ST_DN_FUNC:  begin w.strb = slot_strb(SLOT_FUNC);  w.data = 8'h00; end
            ST_DN_VDIG:  begin w.strb = slot_strb(SLOT_VDIG);  w.data = 8'h01; end
            ST_DN_VCORE: begin w.strb = slot_strb(SLOT_VCORE); w.data = 8'h01; end
            default:     w = '0;
        endcase
        return w;
    endfunction

endpackage

// File: rtl/bos_seq_timer.sv
// rtl/bos_seq_timer.sv - loadable down-counter pacing each sequencer step
module bos_seq_timer #(
    parameter int CNT_W = 24
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic             load_i,
    input  logic [CNT_W-1:0] value_i,
    output logic             zero_o
);

    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            cnt_q <= '0;
        end else if (load_i) begin
            cnt_q <= value_i;
        end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - CNT_W'(1);
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/bos_power_seq.sv
// rtl/bos_power_seq.sv - BOS supply power-up/down sequencer sharing the fpga_regs write port with host writes
// Optional PWR_SEQ_ABORT_EN: pwr_dn during power-up unwinds from the last completed step.
module bos_power_seq
    import bos_pkg::*;
#(
    parameter int CNT_W   = 24,
    parameter int T_VCORE = 100000,
    parameter int T_VDIG  = 100000,
    parameter int T_FUNC  = 10000,
    parameter int T_RST   = 1000,
    parameter int T_DOWN  = 10000
) (
    input  logic       clk,
    input  logic       n_rst,
    input  logic       pwr_up,
    input  logic       pwr_dn,
    input  logic [7:0] host_data,
    input  logic [9:0] host_valid,
    output logic [7:0] master_data,
    output logic [9:0] valid_bus,
    output logic       busy,
    output logic       pwr_on,
    output logic       host_drop,
    output logic [3:0] seq_state
);

    state_e           state_q, state_d;
    logic             entry_q;
    logic             pend_q, pend_d;
    logic [9:0]       vbus_q, vbus_d;
    logic [7:0]       mdata_q, mdata_d;
    logic             hold_vld_q, hold_vld_d;
    logic [9:0]       hold_strb_q, hold_strb_d;
    logic [7:0]       hold_data_q, hold_data_d;
    logic             drop_q, drop_d;
    logic             busy_q, busy_d;
    logic             on_q, on_d;

    logic             tmr_load;
    logic [CNT_W-1:0] tmr_val;
    logic             tmr_zero;
    wr_t              seq_wr;
    logic             host_acc;

    bos_seq_timer #(.CNT_W(CNT_W)) u_timer (
        .clk     (clk),
        .n_rst   (n_rst),
        .load_i  (tmr_load),
        .value_i (tmr_val),
        .zero_o  (tmr_zero)
    );

    always_comb begin
        state_d = state_q;
        pend_d  = pend_q;
        case (state_q)
            ST_OFF:      if (pwr_up && !pwr_dn) state_d = ST_UP_VCORE;
            ST_UP_VCORE: if (tmr_zero) state_d = ST_UP_VDIG;
            ST_UP_VDIG:  if (tmr_zero) state_d = ST_UP_FUNC;
            ST_UP_FUNC:  if (tmr_zero) state_d = ST_UP_RST;
            ST_UP_RST:   if (tmr_zero) state_d = ST_UP_REL;
            ST_UP_REL:   state_d = ST_ON;
            ST_ON: begin
                if (pwr_dn || pend_q) begin
                    state_d = ST_DN_RST;
                    pend_d  = 1'b0;
                end
            end
            ST_DN_RST:   if (tmr_zero) state_d = ST_DN_FUNC;
            ST_DN_FUNC:  if (tmr_zero) state_d = ST_DN_VDIG;
            ST_DN_VDIG:  if (tmr_zero) state_d = ST_DN_VCORE;
            ST_DN_VCORE: if (tmr_zero) state_d = ST_OFF;
            default:     state_d = ST_OFF;
        endcase
`ifdef PWR_SEQ_ABORT_EN
        if (pwr_dn) begin
            case (state_q)
                ST_UP_VCORE:          state_d = ST_DN_VCORE;
                ST_UP_VDIG:           state_d = ST_DN_VDIG;
                ST_UP_FUNC:           state_d = ST_DN_FUNC;
                ST_UP_RST, ST_UP_REL: state_d = ST_DN_RST;
                default:              ;
            endcase
        end
`else
        if (pwr_dn && is_up(state_q)) pend_d = 1'b1;
`endif
    end

    // Load on every transition so the first cycle of a step already sees T-1
    always_comb begin
        tmr_load = (state_d != state_q);
        case (state_d)
            ST_UP_VCORE: tmr_val = CNT_W'(T_VCORE - 1);
            ST_UP_VDIG:  tmr_val = CNT_W'(T_VDIG - 1);
            ST_UP_FUNC:  tmr_val = CNT_W'(T_FUNC - 1);
            ST_UP_RST:   tmr_val = CNT_W'(T_RST - 1);
            ST_DN_RST, ST_DN_FUNC, ST_DN_VDIG, ST_DN_VCORE:
                         tmr_val = CNT_W'(T_DOWN - 1);
            default:     tmr_val = '0;
        endcase
    end

    assign seq_wr   = entry_q ? step_write(state_q) : '0;
    assign drop_d   = busy_q && (|host_valid[9:6]);
    assign host_acc = (|host_valid) && !drop_d;
    assign busy_d   = !(state_d inside {ST_OFF, ST_ON});
    assign on_d     = (state_d == ST_ON);

    // Port arbitration: sequencer first, then a parked host write, then the live host write
    always_comb begin
        vbus_d      = '0;
        mdata_d     = '0;
        hold_vld_d  = hold_vld_q;
        hold_strb_d = hold_strb_q;
        hold_data_d = hold_data_q;
        if (|seq_wr.strb) begin
            vbus_d  = seq_wr.strb;
            mdata_d = seq_wr.data;
            if (host_acc) begin
                hold_vld_d  = 1'b1;
                hold_strb_d = host_valid;
                hold_data_d = host_data;
            end
        end else if (hold_vld_q) begin
            vbus_d     = hold_strb_q;
            mdata_d    = hold_data_q;
            hold_vld_d = host_acc;
            if (host_acc) begin
                hold_strb_d = host_valid;
                hold_data_d = host_data;
            end
        end else if (host_acc) begin
            vbus_d  = host_valid;
            mdata_d = host_data;
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q     <= ST_OFF;
            entry_q     <= 1'b0;
            pend_q      <= 1'b0;
            vbus_q      <= '0;
            mdata_q     <= '0;
            hold_vld_q  <= 1'b0;
            hold_strb_q <= '0;
            hold_data_q <= '0;
            drop_q      <= 1'b0;
            busy_q      <= 1'b0;
            on_q        <= 1'b0;
        end else begin
            state_q     <= state_d;
            entry_q     <= (state_d != state_q);
            pend_q      <= pend_d;
            vbus_q      <= vbus_d;
            mdata_q     <= mdata_d;
            hold_vld_q  <= hold_vld_d;
            hold_strb_q <= hold_strb_d;
            hold_data_q <= hold_data_d;
            drop_q      <= drop_d;
            busy_q      <= busy_d;
            on_q        <= on_d;
        end
    end

    assign master_data = mdata_q;
    assign valid_bus   = vbus_q;
    assign busy        = busy_q;
    assign pwr_on      = on_q;
    assign host_drop   = drop_q;
    assign seq_state   = 4'(state_q);

endmodule
